oq_mem_scheduler: RTL and testbench
===================================

OQ_MEM_SCHEDULER -- requirements
Module: oq_mem_scheduler

Interface
REQ-001 SHALL have parameter NUM_QUEUES, default 5: number of output queues sharing the SRAM.
REQ-002 SHALL have parameter QUEUE_ID_WIDTH, default 3: width of queue-id fields.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 19: SRAM word-address width.
REQ-004 SHALL have parameter QUEUE_SIZE, default 104857: words per queue region (MEM_NUM_WORDS/5, truncated).
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port wr_req, input, 1: one word is waiting to be written to queue wr_qid.
REQ-008 SHALL have port wr_qid, input, QUEUE_ID_WIDTH: target queue of the pending write.
REQ-009 SHALL have port wr_grant, output, 1: one-cycle pulse when the write command is accepted by the SRAM.
REQ-010 SHALL have port wr_drop, output, 1: one-cycle pulse when the pending write is discarded.
REQ-011 SHALL have port rd_ready, input, NUM_QUEUES: per queue, the downstream queue can accept one word.
REQ-012 SHALL have port rd_issue, output, NUM_QUEUES: one-hot, one-cycle pulse when the read command is accepted.
REQ-013 SHALL have port mem_cmd_valid, output, 1: SRAM command valid.
REQ-014 SHALL have port mem_cmd_ready, input, 1: SRAM controller accepts the command.
REQ-015 SHALL have port mem_cmd_we, output, 1: 1 = write, 0 = read.
REQ-016 SHALL have port mem_cmd_addr, output, MEM_ADDR_WIDTH: SRAM word address.
REQ-017 SHALL have port mem_cmd_qid, output, QUEUE_ID_WIDTH: queue owning the command.
REQ-018 SHALL have port q_empty, output, NUM_QUEUES: per-queue empty flag.
REQ-019 SHALL have port q_full, output, NUM_QUEUES: per-queue full flag.

Function
REQ-020 SHALL keep, per queue q: wr_ptr, rd_ptr and count.
- wr_ptr, rd_ptr: ceil(log2(QUEUE_SIZE)) bits each.
- count: ceil(log2(QUEUE_SIZE+1)) bits.
REQ-021 SHALL form the address as q*QUEUE_SIZE + ptr; the base is a constant per queue, with no runtime multiply.
REQ-022 SHALL wrap a pointer from QUEUE_SIZE-1 to 0 when it advances.
REQ-023 SHALL derive q_empty = (count==0) and q_full = (count==QUEUE_SIZE) combinationally from registers.
REQ-024 SHALL implement FSM states ARB and CMD, resetting to ARB.
REQ-025 In ARB:
- write eligible = wr_req, wr_qid<NUM_QUEUES and !q_full[wr_qid].
- read eligible = any q with rd_ready[q] && !q_empty[q].
REQ-026 In ARB, when wr_req is set and wr_qid>=NUM_QUEUES or the target queue is full: SHALL pulse wr_drop, issue no write, and stay in ARB.
REQ-027 When only one side is eligible, it SHALL be chosen; when both are, the side SHALL alternate on a priority toggle, starting with write after reset.
- The toggle flips only on a contested choice.
REQ-028 Read queue selection SHALL be round-robin: search starts at last-served queue +1, modulo NUM_QUEUES; last-served resets to NUM_QUEUES-1.
REQ-029 On a choice, the command fields SHALL be registered and the FSM moves to CMD; mem_cmd_valid rises the cycle after the ARB decision.
REQ-030 In CMD, mem_cmd_valid SHALL stay high and all command fields stable until mem_cmd_ready; then return to ARB.
- Minimum spacing between commands: 2 cycles.
REQ-031 On handshake:
- write: wr_ptr++ and count++, wr_grant pulse in the same cycle.
- read: rd_ptr++ and count--, rd_issue[q] pulse in the same cycle.
REQ-032 Only one command is outstanding, so a queue's count SHALL never see simultaneous increment and decrement.
REQ-033 wr_req and rd_ready changes SHALL have no effect while in CMD.
REQ-034 mem_cmd_valid SHALL be 0 in ARB.

Reset
REQ-035 SHALL clear on reset, including mid-command, where any unaccepted command is abandoned:
- all pointers and counts = 0;
- FSM = ARB;
- mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_qid = 0;
- wr_grant, wr_drop, rd_issue = 0;
- q_empty all 1, q_full all 0.

Structure
REQ-036 The shared package oq_pkg SHALL hold NUM_QUEUES, QUEUE_SIZE, address and pointer widths, the per-queue base-address constant function, and the FSM state enum.
REQ-037 SHALL instantiate one sub-module, oq_rr_arbiter: NUM_QUEUES request vector and last-grant pointer in, one-hot grant and valid out, purely combinational.

Verification
REQ-038 Reset, then wr_req=1, wr_qid=2, mem_cmd_ready=1 -> cmd we=1, addr=209714, a cycle later wr_grant; count[2]=1, q_empty[2]=0.
REQ-039 Queue 0 preloaded with 3 words, rd_ready=5'b00001 -> 3 reads at addr 0,1,2 with rd_issue[0] pulses, then q_empty[0]=1 and no further commands.
REQ-040 Writes to queue 4 until full -> q_full[4]=1 at count 104857; the next wr_req to queue 4 -> wr_drop pulse, no command; wr_qid=5 -> wr_drop.
REQ-041 wr_ptr[1]=QUEUE_SIZE-1, one write -> addr=209713, and wr_ptr[1] wraps to 0.
REQ-042 Write and read both eligible continuously -> command sequence W,R,W,R; reads rotate queues 0,1,2 when all three are non-empty and ready.
REQ-043 mem_cmd_ready held 0 for 5 cycles in CMD -> valid and fields stable; reset asserted in cycle 3 -> valid=0 immediately and count unchanged from 0.

Source files
------------

// File: rtl/oq_pkg.sv
// Shared constants, base-address helper and FSM state type for the
// output-queue SRAM scheduler.
package oq_pkg;

  localparam int unsigned NUM_QUEUES     = 5;
  localparam int unsigned QUEUE_ID_WIDTH = 3;
  localparam int unsigned MEM_ADDR_WIDTH = 19;
  localparam int unsigned MEM_NUM_WORDS  = 524288;
  localparam int unsigned QUEUE_SIZE     = MEM_NUM_WORDS / NUM_QUEUES;
  localparam int unsigned PTR_WIDTH      = $clog2(QUEUE_SIZE);
  localparam int unsigned CNT_WIDTH      = $clog2(QUEUE_SIZE + 1);

  typedef enum logic {
    ARB = 1'b0,
    CMD = 1'b1
  } state_t;

  // Elaboration-time base address of a queue region.
  function automatic int unsigned queue_base(input int unsigned q, input int unsigned size);
    return q * size;
  endfunction

endpackage

// File: rtl/oq_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
module oq_rr_arbiter #(
  parameter int unsigned N   = oq_pkg::NUM_QUEUES,
  parameter int unsigned IDW = oq_pkg::QUEUE_ID_WIDTH
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   grant,
  output logic           valid
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  int unsigned idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = 32'(last_grant) + i;
      if (idx >= N) idx = idx - N;
      if (!valid && req[IW'(idx)]) begin
        grant[IW'(idx)] = 1'b1;
        valid           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oq_mem_scheduler.sv
// Schedules single-word writes and reads of several circular output queues
// that share one SRAM, with one command outstanding at a time.
module oq_mem_scheduler #(
  parameter int unsigned NUM_QUEUES     = oq_pkg::NUM_QUEUES,
  parameter int unsigned QUEUE_ID_WIDTH = oq_pkg::QUEUE_ID_WIDTH,
  parameter int unsigned MEM_ADDR_WIDTH = oq_pkg::MEM_ADDR_WIDTH,
  parameter int unsigned QUEUE_SIZE     = oq_pkg::QUEUE_SIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_req,
  input  logic [QUEUE_ID_WIDTH-1:0] wr_qid,
  output logic                      wr_grant,
  output logic                      wr_drop,
  input  logic [NUM_QUEUES-1:0]     rd_ready,
  output logic [NUM_QUEUES-1:0]     rd_issue,
  output logic                      mem_cmd_valid,
  input  logic                      mem_cmd_ready,
  output logic                      mem_cmd_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_cmd_addr,
  output logic [QUEUE_ID_WIDTH-1:0] mem_cmd_qid,
  output logic [NUM_QUEUES-1:0]     q_empty,
  output logic [NUM_QUEUES-1:0]     q_full
);

  import oq_pkg::*;

  localparam int unsigned PTR_W = $clog2(QUEUE_SIZE);
  localparam int unsigned CNT_W = $clog2(QUEUE_SIZE + 1);

  state_t state, state_n;

  logic [PTR_W-1:0]          wr_ptr [NUM_QUEUES];
  logic [PTR_W-1:0]          rd_ptr [NUM_QUEUES];
  logic [CNT_W-1:0]          count  [NUM_QUEUES];
  logic [MEM_ADDR_WIDTH-1:0] base   [NUM_QUEUES];

  logic                      prio_wr;
  logic [QUEUE_ID_WIDTH-1:0] last_rd;
  logic [NUM_QUEUES-1:0]     rd_req, rd_grant;
  logic                      rd_valid;
  logic [QUEUE_ID_WIDTH-1:0] rd_qid;
  logic                      wr_ok, wr_full, wr_elig;
  logic                      take_wr, take_rd, drop_c, toggle, handshake;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Constant region bases and status flags per queue.
  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
    assign base[g]    = MEM_ADDR_WIDTH'(queue_base(g, QUEUE_SIZE));
    assign q_empty[g] = (count[g] == '0);
    assign q_full[g]  = (count[g] == CNT_W'(QUEUE_SIZE));
    assign rd_req[g]  = rd_ready[g] & ~q_empty[g];
  end

  assign wr_ok   = (32'(wr_qid) < NUM_QUEUES);
  assign wr_full = wr_ok ? q_full[wr_qid] : 1'b0;
  assign wr_elig = wr_req & wr_ok & ~wr_full;

  oq_rr_arbiter #(
    .N   (NUM_QUEUES),
    .IDW (QUEUE_ID_WIDTH)
  ) u_rr (
    .req        (rd_req),
    .last_grant (last_rd),
    .grant      (rd_grant),
    .valid      (rd_valid)
  );

  always_comb begin
    rd_qid = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (rd_grant[i]) rd_qid = QUEUE_ID_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB;
    else       state <= state_n;
  end

  // A rejected write consumes the arbitration cycle; contested picks alternate.
  always_comb begin
    state_n   = state;
    take_wr   = 1'b0;
    take_rd   = 1'b0;
    drop_c    = 1'b0;
    toggle    = 1'b0;
    handshake = 1'b0;
    unique case (state)
      ARB: begin
        if (wr_req && !wr_elig) begin
          drop_c = 1'b1;
        end else if (wr_elig && rd_valid) begin
          take_wr = prio_wr;
          take_rd = ~prio_wr;
          toggle  = 1'b1;
          state_n = CMD;
        end else if (wr_elig) begin
          take_wr = 1'b1;
          state_n = CMD;
        end else if (rd_valid) begin
          take_rd = 1'b1;
          state_n = CMD;
        end
      end
      CMD: begin
        if (mem_cmd_ready) begin
          handshake = 1'b1;
          state_n   = ARB;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      prio_wr       <= 1'b1;
      last_rd       <= QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
      mem_cmd_valid <= 1'b0;
      mem_cmd_we    <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_qid   <= '0;
      wr_grant      <= 1'b0;
      wr_drop       <= 1'b0;
      rd_issue      <= '0;
    end else begin
      wr_grant <= 1'b0;
      wr_drop  <= drop_c;
      rd_issue <= '0;
      if (toggle) prio_wr <= ~prio_wr;
      if (take_wr) begin
        mem_cmd_valid <= 1'b1;
        mem_cmd_we    <= 1'b1;
        mem_cmd_qid   <= wr_qid;
        mem_cmd_addr  <= base[wr_qid] + MEM_ADDR_WIDTH'(wr_ptr[wr_qid]);
      end
      if (take_rd) begin
        mem_cmd_valid <= 1'b1;
        mem_cmd_we    <= 1'b0;
        mem_cmd_qid   <= rd_qid;
        mem_cmd_addr  <= base[rd_qid] + MEM_ADDR_WIDTH'(rd_ptr[rd_qid]);
        last_rd       <= rd_qid;
      end
      // Pointer/count update happens only on acceptance, so inc and dec never collide.
      if (handshake) begin
        mem_cmd_valid <= 1'b0;
        if (mem_cmd_we) begin
          wr_ptr[mem_cmd_qid] <= ptr_next(wr_ptr[mem_cmd_qid]);
          count[mem_cmd_qid]  <= count[mem_cmd_qid] + CNT_W'(1);
          wr_grant            <= 1'b1;
        end else begin
          rd_ptr[mem_cmd_qid] <= ptr_next(rd_ptr[mem_cmd_qid]);
          count[mem_cmd_qid]  <= count[mem_cmd_qid] - CNT_W'(1);
          rd_issue            <= NUM_QUEUES'(1) << mem_cmd_qid;
        end
      end
    end
  end

endmodule

// File: tb/tb_oq_mem_scheduler.sv
// Bench for oq_mem_scheduler: a small-queue instance checked against a
// transaction-level model, plus a default-size instance for real addresses.
module tb_oq_mem_scheduler;

  localparam int N   = 5;
  localparam int QS  = 6;
  localparam int BQS = 104857;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_req;
  logic [2:0]  wr_qid;
  logic [4:0]  rd_ready;
  logic        mem_cmd_ready;

  logic        wr_grant, wr_drop, mem_cmd_valid, mem_cmd_we;
  logic [4:0]  rd_issue, q_empty, q_full;
  logic [18:0] mem_cmd_addr;
  logic [2:0]  mem_cmd_qid;

  logic        b_wr_grant, b_wr_drop, b_mem_cmd_valid, b_mem_cmd_we;
  logic [4:0]  b_rd_issue, b_q_empty, b_q_full;
  logic [18:0] b_mem_cmd_addr;
  logic [2:0]  b_mem_cmd_qid;

  always #5 clk = ~clk;

  oq_mem_scheduler #(.QUEUE_SIZE(QS)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_qid(wr_qid),
    .wr_grant(wr_grant), .wr_drop(wr_drop), .rd_ready(rd_ready), .rd_issue(rd_issue),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_qid(mem_cmd_qid), .q_empty(q_empty), .q_full(q_full)
  );

  oq_mem_scheduler dut_big (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_qid(wr_qid),
    .wr_grant(b_wr_grant), .wr_drop(b_wr_drop), .rd_ready(rd_ready), .rd_issue(b_rd_issue),
    .mem_cmd_valid(b_mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(b_mem_cmd_we),
    .mem_cmd_addr(b_mem_cmd_addr), .mem_cmd_qid(b_mem_cmd_qid), .q_empty(b_q_empty), .q_full(b_q_full)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: queue occupancy plus the one outstanding command.
  int cnt [N];
  int wp  [N];
  int rp  [N];
  bit busy, cur_we, prio_w, e_grant, e_drop;
  int cur_q, cur_addr, last_q, e_issue;
  int cmd_log[$];
  bit prev_valid;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0; wp[i] = 0; rp[i] = 0;
    end
    busy = 0; cur_we = 0; cur_q = 0; cur_addr = 0;
    prio_w = 1; last_q = N - 1;
    e_grant = 0; e_drop = 0; e_issue = 0;
  endfunction

  function automatic void model_step();
    bit w_ok, pick_w;
    int rq, q;
    e_grant = 0; e_drop = 0; e_issue = 0;
    if (busy) begin
      if (mem_cmd_ready) begin
        busy = 0;
        if (cur_we) begin
          cnt[cur_q]++; wp[cur_q] = (wp[cur_q] + 1) % QS; e_grant = 1;
        end else begin
          cnt[cur_q]--; rp[cur_q] = (rp[cur_q] + 1) % QS; e_issue = 1 << cur_q;
        end
      end
    end else begin
      w_ok = 0;
      if (wr_req && int'(wr_qid) < N) w_ok = (cnt[int'(wr_qid)] < QS);
      rq = -1;
      for (int k = 1; k <= N; k++) begin
        q = (last_q + k) % N;
        if (rq < 0 && rd_ready[3'(q)] && cnt[q] > 0) rq = q;
      end
      if (wr_req && !w_ok) begin
        e_drop = 1;
      end else if (w_ok || rq >= 0) begin
        if (w_ok && rq >= 0) begin
          pick_w = prio_w; prio_w = !prio_w;
        end else begin
          pick_w = w_ok;
        end
        busy = 1;
        if (pick_w) begin
          cur_we = 1; cur_q = int'(wr_qid); cur_addr = cur_q * QS + wp[cur_q];
        end else begin
          cur_we = 0; cur_q = rq; cur_addr = rq * QS + rp[rq]; last_q = rq;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else       model_step();
    if (mem_cmd_valid && !prev_valid)
      cmd_log.push_back((int'(mem_cmd_we) << 24) | (int'(mem_cmd_qid) << 20) | int'(mem_cmd_addr));
    prev_valid = mem_cmd_valid;
  endtask

  task automatic check_model();
    logic [4:0] xe, xf;
    for (int i = 0; i < N; i++) begin
      xe[i] = (cnt[i] == 0);
      xf[i] = (cnt[i] == QS);
    end
    chk("valid", 32'(mem_cmd_valid), 32'(busy));
    chk("we",    32'(mem_cmd_we),    32'(cur_we));
    chk("addr",  32'(mem_cmd_addr),  32'(cur_addr));
    chk("qid",   32'(mem_cmd_qid),   32'(cur_q));
    chk("grant", 32'(wr_grant),      32'(e_grant));
    chk("drop",  32'(wr_drop),       32'(e_drop));
    chk("issue", 32'(rd_issue),      32'(e_issue));
    chk("empty", 32'(q_empty),       32'(xe));
    chk("full",  32'(q_full),        32'(xf));
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_req = 1'b0; wr_qid = '0; rd_ready = '0; mem_cmd_ready = 1'b0;
    tick();
    reset = 1'b0;
    check_model();
  endtask

  typedef struct {
    logic        wr_req;
    logic [2:0]  wr_qid;
    logic [4:0]  rd_ready;
    logic        mready;
    logic        exp_valid;
    logic        exp_we;
    logic [18:0] exp_addr;
    logic [18:0] exp_baddr;
    logic        exp_grant;
    logic        exp_drop;
    logic [4:0]  exp_issue;
    logic [4:0]  exp_empty;
  } vec_t;

  vec_t tbl [10];
  int   issues;
  int   exp_seq [8];
  int   ent;

  initial begin
    tbl[0] = '{1'b1, 3'd2, 5'b00000, 1'b1, 1'b1, 1'b1, 19'd12, 19'd209714, 1'b0, 1'b0, 5'b00000, 5'b11111};
    tbl[1] = '{1'b1, 3'd2, 5'b00000, 1'b1, 1'b0, 1'b1, 19'd12, 19'd209714, 1'b1, 1'b0, 5'b00000, 5'b11011};
    tbl[2] = '{1'b1, 3'd7, 5'b00000, 1'b1, 1'b0, 1'b1, 19'd12, 19'd209714, 1'b0, 1'b1, 5'b00000, 5'b11011};
    tbl[3] = '{1'b0, 3'd0, 5'b00100, 1'b0, 1'b1, 1'b0, 19'd12, 19'd209714, 1'b0, 1'b0, 5'b00000, 5'b11011};
    tbl[4] = '{1'b0, 3'd0, 5'b00100, 1'b0, 1'b1, 1'b0, 19'd12, 19'd209714, 1'b0, 1'b0, 5'b00000, 5'b11011};
    tbl[5] = '{1'b0, 3'd0, 5'b00000, 1'b1, 1'b0, 1'b0, 19'd12, 19'd209714, 1'b0, 1'b0, 5'b00100, 5'b11111};
    tbl[6] = '{1'b0, 3'd0, 5'b00100, 1'b1, 1'b0, 1'b0, 19'd12, 19'd209714, 1'b0, 1'b0, 5'b00000, 5'b11111};
    tbl[7] = '{1'b1, 3'd5, 5'b00000, 1'b1, 1'b0, 1'b0, 19'd12, 19'd209714, 1'b0, 1'b1, 5'b00000, 5'b11111};
    tbl[8] = '{1'b1, 3'd2, 5'b00000, 1'b1, 1'b1, 1'b1, 19'd13, 19'd209715, 1'b0, 1'b0, 5'b00000, 5'b11111};
    tbl[9] = '{1'b1, 3'd2, 5'b00000, 1'b1, 1'b0, 1'b1, 19'd13, 19'd209715, 1'b1, 1'b0, 5'b00000, 5'b11011};

    prev_valid = 1'b0;
    model_reset();
    reset = 1'b1; wr_req = 1'b0; wr_qid = '0; rd_ready = '0; mem_cmd_ready = 1'b0;
    #2;
    do_reset();
    chk("rst_valid",   32'(mem_cmd_valid),   32'd0);
    chk("rst_empty",   32'(q_empty),         32'h1f);
    chk("rst_full",    32'(q_full),          32'h0);
    chk("rst_b_valid", 32'(b_mem_cmd_valid), 32'd0);
    chk("rst_b_addr",  32'(b_mem_cmd_addr),  32'd0);

    // Hand-derived vectors, including the default-size address for queue 2.
    for (int i = 0; i < 10; i++) begin
      wr_req = tbl[i].wr_req; wr_qid = tbl[i].wr_qid;
      rd_ready = tbl[i].rd_ready; mem_cmd_ready = tbl[i].mready;
      tick();
      chk("tbl_valid", 32'(mem_cmd_valid),  32'(tbl[i].exp_valid));
      chk("tbl_we",    32'(mem_cmd_we),     32'(tbl[i].exp_we));
      chk("tbl_addr",  32'(mem_cmd_addr),   32'(tbl[i].exp_addr));
      chk("tbl_baddr", 32'(b_mem_cmd_addr), 32'(tbl[i].exp_baddr));
      chk("tbl_grant", 32'(wr_grant),       32'(tbl[i].exp_grant));
      chk("tbl_drop",  32'(wr_drop),        32'(tbl[i].exp_drop));
      chk("tbl_issue", 32'(rd_issue),       32'(tbl[i].exp_issue));
      chk("tbl_empty", 32'(q_empty),        32'(tbl[i].exp_empty));
    end

    // Three reads drain queue 0 at addresses 0,1,2, then nothing.
    do_reset();
    wr_req = 1'b1; wr_qid = 3'd0; mem_cmd_ready = 1'b1;
    repeat (6) begin tick(); check_model(); end
    wr_req = 1'b0; rd_ready = 5'b00001; issues = 0;
    cmd_log.delete();
    repeat (10) begin
      tick(); check_model();
      if (rd_issue[0]) issues++;
    end
    chk("drain_issues", 32'(issues), 32'd3);
    chk("drain_empty0", 32'(q_empty[0]), 32'd1);
    chk("drain_ncmd", 32'(cmd_log.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      ent = (k < cmd_log.size()) ? cmd_log[k] : -1;
      chk("drain_rd_addr", 32'(ent), 32'(k));
    end

    // Fill queue 4, then drops for a full queue and an illegal id.
    do_reset();
    rd_ready = '0; wr_req = 1'b1; wr_qid = 3'd4; mem_cmd_ready = 1'b1;
    repeat (12) begin tick(); check_model(); end
    chk("full4", 32'(q_full[4]), 32'd1);
    tick(); check_model();
    chk("drop_full", 32'(wr_drop), 32'd1);
    chk("drop_full_nocmd", 32'(mem_cmd_valid), 32'd0);
    wr_qid = 3'd5;
    tick(); check_model();
    chk("drop_badq", 32'(wr_drop), 32'd1);

    // Pointer wrap on queue 1.
    do_reset();
    wr_req = 1'b1; wr_qid = 3'd1; mem_cmd_ready = 1'b1;
    repeat (12) begin tick(); check_model(); end
    chk("wrap_last_addr", 32'(cmd_log[cmd_log.size()-1] & 'hfffff), 32'(1 * QS + QS - 1));
    wr_req = 1'b0; rd_ready = 5'b00010;
    repeat (2) begin tick(); check_model(); end
    rd_ready = '0; wr_req = 1'b1;
    repeat (2) begin tick(); check_model(); end
    chk("wrap_addr", 32'(cmd_log[cmd_log.size()-1]), 32'((1 << 24) | (1 << 20) | (1 * QS)));

    // Contested traffic alternates W/R and reads rotate 0,1,2.
    do_reset();
    wr_req = 1'b1; mem_cmd_ready = 1'b1;
    for (int q = 0; q < 3; q++) begin
      wr_qid = 3'(q);
      repeat (4) begin tick(); check_model(); end
    end
    cmd_log.delete();
    wr_qid = 3'd3; rd_ready = 5'b00111;
    repeat (16) begin tick(); check_model(); end
    exp_seq = '{'h13, 'h00, 'h13, 'h01, 'h13, 'h02, 'h13, 'h00};
    chk("alt_ncmd", 32'(cmd_log.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      ent = (k < cmd_log.size()) ? (cmd_log[k] >> 20) : -1;
      chk("alt_seq", 32'(ent), 32'(exp_seq[k]));
    end

    // Stall in CMD, then asynchronous reset abandons the command.
    do_reset();
    wr_req = 1'b1; wr_qid = 3'd0; mem_cmd_ready = 1'b0;
    repeat (3) begin tick(); check_model(); end
    chk("stall_valid", 32'(mem_cmd_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid",   32'(mem_cmd_valid),   32'd0);
    chk("async_b_valid", 32'(b_mem_cmd_valid), 32'd0);
    chk("async_addr",    32'(mem_cmd_addr),    32'd0);
    chk("async_empty0",  32'(q_empty[0]),      32'd1);
    model_reset();
    tick();
    reset = 1'b0; wr_req = 1'b0;
    check_model();

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    repeat (3000) begin
      wr_req        = ($urandom_range(0, 9) < 6);
      wr_qid        = 3'($urandom_range(0, 6));
      rd_ready      = 5'($urandom);
      mem_cmd_ready = ($urandom_range(0, 9) < 7);
      reset         = ($urandom_range(0, 499) == 0);
      tick();
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
